// File: rtl/dtm_jtag.sv
// JTAG Debug Transport Module. This is the DMI initiator that drives the debug module's
// responder port. The whole design runs in the clk domain: it oversamples the JTAG pins
// and turns each DMI scan into at most one valid/ready bus transaction.
//
// Ports:
//   clk, resetn        system clock and synchronous active-low reset
//   jtag_tck/tms/tdi   asynchronous JTAG inputs, each passed through a 2-flop synchroniser
//   jtag_tdo           registered JTAG data out, updated on each detected TCK fall
//   dmi_valid/ready    DMI request handshake
//   dmi_write          1 = write, 0 = read
//   dmi_addr/wdata     request address and write data, held while dmi_valid is high
//   dmi_rdata          read data, sampled in the cycle where dmi_valid && dmi_ready
module dtm_jtag #(
   parameter logic [31:0] IDCODE    = 32'h0000_0001,
   parameter int unsigned DMI_ABITS = 7
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 jtag_tck,
   input  logic                 jtag_tms,
   input  logic                 jtag_tdi,
   output logic                 jtag_tdo,
   output logic                 dmi_valid,
   input  logic                 dmi_ready,
   output logic                 dmi_write,
   output logic [DMI_ABITS-1:0] dmi_addr,
   output logic [31:0]          dmi_wdata,
   input  logic [31:0]          dmi_rdata
);

   localparam int unsigned DmiLen     = DMI_ABITS + 34;
   localparam logic [4:0]  IrIdcode   = 5'h01;
   localparam logic [4:0]  IrDtmcs    = 5'h10;
   localparam logic [4:0]  IrDmi      = 5'h11;
   localparam logic [5:0]  AbitsField = 6'(DMI_ABITS);

   typedef enum logic [3:0] {
      StTlr, StRti, StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdDr,
      StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdIr
   } tap_state_e;

   // tck_sync[1] is the synchronised TCK, tck_sync[2] its delayed copy for edge detection.
   logic [2:0]        tck_sync;
   logic [1:0]        tms_sync;
   logic [1:0]        tdi_sync;
   tap_state_e        tap_q;
   tap_state_e        tap_d;
   logic [4:0]        ir_q;
   logic [4:0]        ir_shift_q;
   logic [DmiLen-1:0] dr_shift_q;
   logic [DmiLen-1:0] dr_shift_d;
   logic [DmiLen-1:0] dr_shifted;
   logic [DmiLen-1:0] dr_capture;
   int                dr_len;
   logic              sticky_busy_q;
   logic              discard_q;
   logic [31:0]       rdata_q;
   logic              tck_rise;
   logic              tck_fall;
   logic              tms;
   logic              tdi;
   logic              upd_dr;
   logic              in_ir_path;
   logic [1:0]        dmi_op;

   assign tck_rise   = tck_sync[1] & ~tck_sync[2];
   assign tck_fall   = ~tck_sync[1] & tck_sync[2];
   assign tms        = tms_sync[1];
   assign tdi        = tdi_sync[1];
   assign upd_dr     = tck_rise && (tap_q == StUpdDr);
   assign dmi_op     = dr_shift_q[1:0];
   assign in_ir_path = tap_q inside {StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir};
   assign dr_shifted = {1'b0, dr_shift_q[DmiLen-1:1]};

   always_comb begin
      tap_d = tap_q;
      case (tap_q)
         StTlr:     tap_d = tms ? StTlr     : StRti;
         StRti:     tap_d = tms ? StSelDr   : StRti;
         StSelDr:   tap_d = tms ? StSelIr   : StCapDr;
         StCapDr:   tap_d = tms ? StExit1Dr : StShiftDr;
         StShiftDr: tap_d = tms ? StExit1Dr : StShiftDr;
         StExit1Dr: tap_d = tms ? StUpdDr   : StPauseDr;
         StPauseDr: tap_d = tms ? StExit2Dr : StPauseDr;
         StExit2Dr: tap_d = tms ? StUpdDr   : StShiftDr;
         StUpdDr:   tap_d = tms ? StSelDr   : StRti;
         StSelIr:   tap_d = tms ? StTlr     : StCapIr;
         StCapIr:   tap_d = tms ? StExit1Ir : StShiftIr;
         StShiftIr: tap_d = tms ? StExit1Ir : StShiftIr;
         StExit1Ir: tap_d = tms ? StUpdIr   : StPauseIr;
         StPauseIr: tap_d = tms ? StExit2Ir : StPauseIr;
         StExit2Ir: tap_d = tms ? StUpdIr   : StShiftIr;
         StUpdIr:   tap_d = tms ? StSelDr   : StRti;
         default:   tap_d = StTlr;
      endcase
   end

   // Selected DR: capture value and length. Unknown opcodes fall through to BYPASS.
   always_comb begin
      dr_capture = '0;
      dr_len     = 1;
      case (ir_q)
         IrIdcode: begin
            dr_capture[31:0] = IDCODE;
            dr_len           = 32;
         end
         IrDtmcs: begin
            dr_capture[31:0] = {17'b0, 3'd1, {2{sticky_busy_q}}, AbitsField, 4'd1};
            dr_len           = 32;
         end
         IrDmi: begin
            dr_capture = {dmi_addr, rdata_q, (sticky_busy_q || dmi_valid) ? 2'b11 : 2'b00};
            dr_len     = int'(DmiLen);
         end
         default: ;
      endcase
   end

   // One shared shift register; TDI enters at the MSB of the selected register's length.
   always_comb begin
      dr_shift_d = '0;
      for (int i = 0; i < int'(DmiLen); i++) begin
         if (i == dr_len - 1) begin
            dr_shift_d[i] = tdi;
         end else if (i < dr_len - 1) begin
            dr_shift_d[i] = dr_shifted[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tck_sync      <= '0;
         tms_sync      <= '0;
         tdi_sync      <= '0;
         tap_q         <= StTlr;
         ir_q          <= IrIdcode;
         ir_shift_q    <= '0;
         dr_shift_q    <= '0;
         jtag_tdo      <= 1'b0;
         sticky_busy_q <= 1'b0;
         discard_q     <= 1'b0;
         rdata_q       <= '0;
         dmi_valid     <= 1'b0;
         dmi_write     <= 1'b0;
         dmi_addr      <= '0;
         dmi_wdata     <= '0;
      end else begin
         tck_sync <= {tck_sync[1:0], jtag_tck};
         tms_sync <= {tms_sync[0], jtag_tms};
         tdi_sync <= {tdi_sync[0], jtag_tdi};

         if (tck_rise) begin
            tap_q <= tap_d;
            case (tap_q)
               StTlr:     ir_q       <= IrIdcode;
               StCapIr:   ir_shift_q <= 5'b00001;
               StShiftIr: ir_shift_q <= {tdi, ir_shift_q[4:1]};
               StUpdIr:   ir_q       <= ir_shift_q;
               StCapDr:   dr_shift_q <= dr_capture;
               StShiftDr: dr_shift_q <= dr_shift_d;
               default: ;
            endcase
         end

         if (tck_fall) begin
            jtag_tdo <= in_ir_path ? ir_shift_q[0] : dr_shift_q[0];
         end

         // Bus completion; a hardreset below in the same cycle overrides the latched data.
         if (dmi_valid && dmi_ready) begin
            dmi_valid <= 1'b0;
            if (!dmi_write && !discard_q) begin
               rdata_q <= dmi_rdata;
            end
         end

         if (upd_dr && (ir_q == IrDtmcs)) begin
            if (dr_shift_q[16] || dr_shift_q[17]) begin
               sticky_busy_q <= 1'b0;
            end
            if (dr_shift_q[17]) begin
               rdata_q   <= '0;
               discard_q <= dmi_valid;
            end
         end

         // A request still on the bus (including one matching this very cycle) makes a new
         // read/write sticky-busy instead of launching.
         if (upd_dr && (ir_q == IrDmi) && !sticky_busy_q &&
             ((dmi_op == 2'd1) || (dmi_op == 2'd2))) begin
            if (dmi_valid) begin
               sticky_busy_q <= 1'b1;
            end else begin
               dmi_valid <= 1'b1;
               dmi_write <= (dmi_op == 2'd2);
               dmi_addr  <= dr_shift_q[DmiLen-1:34];
               dmi_wdata <= dr_shift_q[33:2];
               discard_q <= 1'b0;
            end
         end
      end
   end

endmodule
